// File: rtl/traffic_cmd_parser.sv
// traffic_cmd_parser
// Assembles 5-byte command frames (HEADER, TYPE, DATA_HI, DATA_LO, CSUM) from a
// byte stream, validates them and issues one-cycle commands to the traffic
// light controller. The operating mode is tracked locally so that SET_* timing
// commands are only forwarded while the controller is in MANUAL mode.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for HEADER_BYTE, other bytes are dropped silently
// GET_TYPE | header seen, next byte is the command type
// GET_HI   | next byte is the payload high byte
// GET_LO   | next byte is the payload low byte
// GET_CSUM | next byte is the checksum; frame is evaluated on its arrival
module traffic_cmd_parser #(
  parameter int          TIMEOUT_CYCLES = 20,
  parameter logic [7:0]  HEADER_BYTE    = 8'hA5,
  parameter int          ERR_CNT_W      = 8
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic [7:0]           byte_data_i,
  input  logic                 byte_valid_i,
  output logic [2:0]           cmd_type_o,
  output logic                 cmd_valid_o,
  output logic [15:0]          cmd_data_o,
  output logic [1:0]           mode_o,
  output logic                 frame_err_o,
  output logic                 rejected_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Expiry is detected on the idle cycle that would bring the count to
  // TIMEOUT_CYCLES, so the compare value is one less.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_OFF    = 2'd1;
  localparam logic [1:0] MODE_MANUAL = 2'd2;

  localparam logic [2:0] CMD_ON     = 3'd0;
  localparam logic [2:0] CMD_OFF    = 3'd1;
  localparam logic [2:0] CMD_MANUAL = 3'd2;
  localparam logic [2:0] CMD_SET_LO = 3'd3;
  localparam logic [2:0] CMD_MAX    = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_TYPE = 3'd1,
    GET_HI   = 3'd2,
    GET_LO   = 3'd3,
    GET_CSUM = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] tmo_d;
  logic [7:0]       type_q;
  logic [7:0]       hi_q;
  logic [7:0]       lo_q;

  logic             frame_done;
  logic             timeout_hit;
  logic             csum_ok;
  logic             type_ok;
  logic             frame_ok;
  logic             is_set;
  logic             eval_err;
  logic             eval_rej;
  logic             eval_cmd;
  logic             err_pulse;

  // Next-state and inter-byte timeout; a byte always wins over expiry.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    frame_done  = 1'b0;
    timeout_hit = 1'b0;
    if (state_q == IDLE) begin
      tmo_d = '0;
      if (byte_valid_i && (byte_data_i == HEADER_BYTE)) begin
        state_d = GET_TYPE;
      end
    end else if (byte_valid_i) begin
      tmo_d = '0;
      case (state_q)
        GET_TYPE: state_d = GET_HI;
        GET_HI:   state_d = GET_LO;
        GET_LO:   state_d = GET_CSUM;
        GET_CSUM: begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
        default:  state_d = IDLE;
      endcase
    end else if (tmo_q == TMO_LAST) begin
      state_d     = IDLE;
      tmo_d       = '0;
      timeout_hit = 1'b1;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  // Frame evaluation on the cycle the checksum byte is accepted.
  always_comb begin
    csum_ok   = (byte_data_i == (type_q ^ hi_q ^ lo_q));
    type_ok   = (type_q[7:3] == 5'd0) && (type_q[2:0] <= CMD_MAX);
    frame_ok  = csum_ok && type_ok;
    is_set    = (type_q[2:0] >= CMD_SET_LO);
    eval_err  = frame_done && !frame_ok;
    eval_rej  = frame_done && frame_ok && is_set && (mode_o != MODE_MANUAL);
    eval_cmd  = frame_done && frame_ok && !(is_set && (mode_o != MODE_MANUAL));
    err_pulse = eval_err || timeout_hit || eval_rej;
  end

  // State register, timeout counter and captured frame bytes.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      type_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (byte_valid_i) begin
        case (state_q)
          GET_TYPE: type_q <= byte_data_i;
          GET_HI:   hi_q   <= byte_data_i;
          GET_LO:   lo_q   <= byte_data_i;
          default:  ;
        endcase
      end
    end
  end

  // Registered command interface and mode tracking.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cmd_valid_o <= 1'b0;
      cmd_type_o  <= '0;
      cmd_data_o  <= '0;
      mode_o      <= MODE_NORMAL;
    end else begin
      cmd_valid_o <= eval_cmd;
      if (eval_cmd) begin
        cmd_type_o <= type_q[2:0];
        cmd_data_o <= {hi_q, lo_q};
        case (type_q[2:0])
          CMD_ON:     mode_o <= MODE_NORMAL;
          CMD_OFF:    mode_o <= MODE_OFF;
          CMD_MANUAL: mode_o <= MODE_MANUAL;
          default:    ;
        endcase
      end
    end
  end

  // Error pulses and the saturating error counter.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      frame_err_o <= 1'b0;
      rejected_o  <= 1'b0;
      err_cnt_o   <= '0;
    end else begin
      frame_err_o <= eval_err || timeout_hit;
      rejected_o  <= eval_rej;
      if (err_pulse && (err_cnt_o != {ERR_CNT_W{1'b1}})) begin
        err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_traffic_cmd_parser.sv
// Scoreboard bench for traffic_cmd_parser: a byte-stream reference model pushes
// expected events, a monitor pops them whenever the DUT pulses an output.
module tb_traffic_cmd_parser;

  localparam int         TMO  = 20;
  localparam logic [7:0] HDR  = 8'hA5;
  localparam int         ECW  = 8;
  localparam int         EMAX = (1 << ECW) - 1;

  logic           clk = 1'b0;
  logic           srst;
  logic [7:0]     byte_data;
  logic           byte_valid;
  logic [2:0]     cmd_type;
  logic           cmd_valid;
  logic [15:0]    cmd_data;
  logic [1:0]     mode;
  logic           frame_err;
  logic           rejected;
  logic [ECW-1:0] err_cnt;

  traffic_cmd_parser #(.TIMEOUT_CYCLES(TMO), .HEADER_BYTE(HDR), .ERR_CNT_W(ECW)) dut (
    .clk_i(clk), .srst_i(srst), .byte_data_i(byte_data), .byte_valid_i(byte_valid),
    .cmd_type_o(cmd_type), .cmd_valid_o(cmd_valid), .cmd_data_o(cmd_data),
    .mode_o(mode), .frame_err_o(frame_err), .rejected_o(rejected), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;   // 0 command, 1 frame error, 2 rejected
    int typ;
    int data;
    int mode;
    int errc;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc_n    = 0;
  int  last_cmd_cyc = -100;
  int  prev_cmd_cyc = -100;
  int  cmd_seen = 0;

  // reference model state
  int m_buf[$];
  int m_gap;
  int m_mode;
  int m_errc;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic void model_reset();
    m_buf.delete();
    m_gap  = 0;
    m_mode = 0;
    m_errc = 0;
  endfunction

  function automatic void push_ev(input int kind, input int typ, input int data);
    ev_t e;
    if (kind != 0 && m_errc < EMAX) m_errc++;
    e.kind = kind; e.typ = typ; e.data = data; e.mode = m_mode; e.errc = m_errc;
    exp_q.push_back(e);
  endfunction

  function automatic void model_eval();
    int t, d;
    t = m_buf[1];
    d = m_buf[2] * 256 + m_buf[3];
    if ((m_buf[4] != (m_buf[1] ^ m_buf[2] ^ m_buf[3])) || t > 5) push_ev(1, 0, 0);
    else if (t >= 3 && m_mode != 2) push_ev(2, 0, 0);
    else begin
      if (t == 0) m_mode = 0;
      else if (t == 1) m_mode = 1;
      else if (t == 2) m_mode = 2;
      push_ev(0, t, d);
    end
  endfunction

  function automatic void model_byte(input int b);
    if (m_buf.size() == 0) begin
      if (b == HDR) m_buf.push_back(b);
    end else begin
      m_buf.push_back(b);
      if (m_buf.size() == 5) begin
        model_eval();
        m_buf.delete();
      end
    end
    m_gap = 0;
  endfunction

  function automatic void model_idle();
    if (m_buf.size() > 0) begin
      m_gap++;
      if (m_gap == TMO) begin
        push_ev(1, 0, 0);
        m_buf.delete();
        m_gap = 0;
      end
    end
  endfunction

  task automatic drive(input bit v, input int b);
    byte_valid = v;
    byte_data  = 8'(b);
    if (v) model_byte(b & 8'hFF);
    else   model_idle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0);
  endtask

  task automatic send5(input int b0, input int b1, input int b2, input int b3, input int b4);
    drive(1'b1, b0); drive(1'b1, b1); drive(1'b1, b2); drive(1'b1, b3); drive(1'b1, b4);
  endtask

  // quiet period then compare tracked mode / error count against the model
  task automatic settle(input string tag);
    idle(3);
    check({tag, "_mode"}, int'(mode), m_mode);
    check({tag, "_errcnt"}, int'(err_cnt), m_errc);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    srst = 1'b1;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_cmd_valid", int'(cmd_valid), 0);
    check("rst_cmd_type", int'(cmd_type), 0);
    check("rst_cmd_data", int'(cmd_data), 0);
    check("rst_mode", int'(mode), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_rejected", int'(rejected), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    srst = 1'b0;
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Monitor: every output pulse consumes one expected event
  always @(negedge clk) begin
    ev_t e;
    int  akind;
    if (!srst && (cmd_valid || frame_err || rejected)) begin
      check("single_pulse", int'(cmd_valid) + int'(frame_err) + int'(rejected), 1);
      akind = cmd_valid ? 0 : (frame_err ? 1 : 2);
      if (cmd_valid) begin
        prev_cmd_cyc = last_cmd_cyc;
        last_cmd_cyc = cyc_n;
        cmd_seen++;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_pulse_kind", akind, -1);
      end else begin
        e = exp_q.pop_front();
        check("ev_kind", akind, e.kind);
        if (e.kind == 0 && akind == 0) begin
          check("ev_cmd_type", int'(cmd_type), e.typ);
          check("ev_cmd_data", int'(cmd_data), e.data);
        end
        check("ev_mode", int'(mode), e.mode);
        check("ev_err_cnt", int'(err_cnt), e.errc);
      end
    end
  end

  initial begin
    int base;
    srst = 1'b1;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    model_reset();
    do_reset();

    // 1: MANUAL
    send5(8'hA5, 8'h02, 8'h00, 8'h00, 8'h02);
    settle("t1");
    check("t1_mode_manual", int'(mode), 2);

    // 2: SET in manual, ON, rejected SET
    send5(8'hA5, 8'h03, 8'h01, 8'h2C, 8'h2E);
    settle("t2a");
    check("t2_data_held", int'(cmd_data), 16'h012C);
    send5(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00);
    send5(8'hA5, 8'h04, 8'h00, 8'h10, 8'h14);
    settle("t2b");
    check("t2_errcnt_one", int'(err_cnt), 1);

    // 3: checksum error, invalid type
    send5(8'hA5, 8'h01, 8'h00, 8'h05, 8'h00);
    send5(8'hA5, 8'h09, 8'h00, 8'h00, 8'h09);
    settle("t3");

    // 4: timeout at 20 idle cycles, none at 19
    drive(1'b1, 8'hA5); drive(1'b1, 8'h01);
    idle(TMO);
    settle("t4a");
    send5(8'hA5, 8'h01, 8'h00, 8'h00, 8'h01);
    settle("t4b");
    drive(1'b1, 8'hA5); drive(1'b1, 8'h02);
    idle(TMO - 1);
    drive(1'b1, 8'h00); drive(1'b1, 8'h00); drive(1'b1, 8'h02);
    settle("t4c");
    check("t4_gap19_manual", int'(mode), 2);

    // 5: garbage then frame; back-to-back frames
    base = cmd_seen;
    drive(1'b1, 8'h00); drive(1'b1, 8'hFF); drive(1'b1, 8'h13);
    send5(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00);
    settle("t5a");
    check("t5_one_strobe", cmd_seen - base, 1);
    send5(8'hA5, 8'h02, 8'h00, 8'h00, 8'h02);
    send5(8'hA5, 8'h05, 8'h12, 8'h34, 8'h05 ^ 8'h12 ^ 8'h34);
    settle("t5b");
    check("t5_b2b_spacing", last_cmd_cyc - prev_cmd_cyc, 5);

    // 6: reset mid-frame
    drive(1'b1, 8'hA5); drive(1'b1, 8'h02); drive(1'b1, 8'h00);
    do_reset();
    drive(1'b1, 8'h00); drive(1'b1, 8'h02);
    settle("t6a");

    // randomized stream
    for (int f = 0; f < 200; f++) begin
      int t, hi, lo, cs;
      if ($urandom_range(0, 9) == 0) drive(1'b1, $urandom_range(0, 255));
      t  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 5) : $urandom_range(0, 255);
      hi = $urandom_range(0, 255);
      lo = $urandom_range(0, 255);
      cs = t ^ hi ^ lo;
      if ($urandom_range(0, 9) == 0) cs = cs ^ (1 << $urandom_range(0, 7));
      drive(1'b1, HDR);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, TMO + 3));
      drive(1'b1, t);
      drive(1'b1, hi);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(TMO - 2, TMO + 1));
      drive(1'b1, lo);
      drive(1'b1, cs);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    idle(TMO + 2);
    settle("rand");

    // saturation
    for (int i = 0; i < 300; i++) send5(8'hA5, 8'h01, 8'h00, 8'h05, 8'h00);
    settle("sat");
    check("sat_errcnt_255", int'(err_cnt), EMAX);

    idle(4);
    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_cmd_parser.md
Name: traffic_cmd_parser

Overview:
Upstream command front-end for the traffic light controller. Receives a byte stream from a serial/host link, assembles and checks 5-byte command frames, and issues single-cycle commands on the controller's cmd_type/cmd_valid/cmd_data interface. It tracks the controller's operating mode so that SET_* timing commands are forwarded only in manual mode. It reports framing errors and rejected commands.

Parameters:
TIMEOUT_CYCLES, 20, max idle cycles between bytes of one frame before the frame is abandoned; must be >= 1.
HEADER_BYTE, 8'hA5, frame start marker.
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk_i  input  1  clock (2000 Hz system clock)
srst_i  input  1  synchronous reset, active-high
byte_data_i  input  8  incoming byte
byte_valid_i  input  1  byte_data_i valid this cycle; no backpressure, every valid byte is consumed
cmd_type_o  output  3  command type to controller (0 ON, 1 OFF, 2 MANUAL, 3 SET_GREEN, 4 SET_RED, 5 SET_YELLOW)
cmd_valid_o  output  1  one-cycle command strobe
cmd_data_o  output  16  command payload (time in clk cycles for SET_*)
mode_o  output  2  tracked mode: 0 NORMAL, 1 OFF, 2 MANUAL
frame_err_o  output  1  one-cycle pulse: bad checksum, bad type or inter-byte timeout
rejected_o  output  1  one-cycle pulse: valid SET_* frame dropped because mode_o != MANUAL
err_cnt_o  output  ERR_CNT_W  saturating count of frame_err_o plus rejected_o pulses

Behaviour:
- Clock/reset: one clock clk_i; reset srst_i is synchronous, active-high.
- Frame format: HEADER_BYTE, TYPE, DATA_HI, DATA_LO, CSUM.
- Checksum: CSUM = TYPE ^ DATA_HI ^ DATA_LO.
- TYPE: bits [2:0] are the command. Bits [7:3] must be 0 and [2:0] must be <= 5, otherwise the type is invalid.
- Reset values: state IDLE; cmd_valid_o 0; cmd_type_o 0; cmd_data_o 0; mode_o NORMAL (the controller comes out of reset cycling normally); frame_err_o 0; rejected_o 0; err_cnt_o 0; timeout counter 0.
- FSM states: IDLE, GET_TYPE, GET_HI, GET_LO, GET_CSUM. Transitions occur only on byte_valid_i:
  - IDLE -> GET_TYPE when the byte equals HEADER_BYTE; any other byte is silently dropped (no error).
  - GET_TYPE -> GET_HI -> GET_LO -> GET_CSUM, each on the next valid byte.
  - GET_CSUM -> IDLE on the next valid byte, after which the frame is evaluated.
  - A HEADER_BYTE value received mid-frame is treated as ordinary data (no resync).
- Frame evaluation, on the cycle the CSUM byte is accepted; outputs are registered and appear the following cycle (latency 1):
  - Checksum mismatch or invalid type: frame_err_o = 1.
  - SET_* (3..5) with mode_o != MANUAL: rejected_o = 1, no command issued.
  - Otherwise: cmd_valid_o = 1, with cmd_type_o/cmd_data_o loaded from the frame. cmd_type_o/cmd_data_o hold their values until the next issued command.
  - mode_o updates in the same cycle as cmd_valid_o: ON -> NORMAL, OFF -> OFF, MANUAL -> MANUAL, SET_* -> unchanged.
- Timeout:
  - In any state other than IDLE, the counter increments on each cycle without byte_valid_i and clears on byte_valid_i.
  - When the count reaches TIMEOUT_CYCLES, the FSM returns to IDLE and frame_err_o pulses the next cycle.
  - A byte arriving in the same cycle the count would expire takes priority: the byte is accepted and no timeout occurs.
  - The counter is 0 in IDLE.
- Back-to-back frames: a HEADER_BYTE in the cycle immediately after CSUM starts a new frame, so a command strobe every 5 cycles is supported.
- err_cnt_o:
  - Adds 1 per error pulse and saturates at all-ones.
  - frame_err_o and rejected_o are mutually exclusive, so the counter never adds 2 in one cycle.
  - Cleared only by reset.
- Reset mid-frame: the partial frame is discarded, all outputs return to reset values, and mode_o returns to NORMAL.
- cmd_valid_o, frame_err_o and rejected_o are never high for more than one consecutive cycle per frame.

Test Plan:
1. Reset, then bytes A5,02,00,00,02 on consecutive cycles -> one cycle after CSUM: cmd_valid_o=1, cmd_type_o=2, cmd_data_o=0000, mode_o=2.
2. In MANUAL, send A5,03,01,2C,2E -> cmd_valid_o=1, cmd_type_o=3, cmd_data_o=012C. Then A5,00,00,00,00 -> type 0 issued, mode_o=0. Then A5,04,00,10,14 -> rejected_o=1, no cmd_valid_o, err_cnt_o=1.
3. Checksum error A5,01,00,05,00 -> frame_err_o=1, no cmd_valid_o, mode_o unchanged. Invalid type A5,09,00,00,09 -> frame_err_o=1.
4. Timeout (TIMEOUT_CYCLES=20): send A5,01 then idle 20 cycles -> frame_err_o pulses once and FSM is in IDLE. Then A5,01,00,00,01 -> OFF issued, mode_o=1. Repeat with a gap of 19 cycles -> frame completes with no error.
5. Garbage 00,FF,13 before A5,00,00,00,00 -> garbage is ignored, exactly one cmd_valid_o. Back-to-back: two frames with no gap -> two strobes 5 cycles apart.
6. srst_i asserted after A5,02,00 -> all outputs at reset values. Bytes 00,02 then sent -> no command issued. Separately, 300 bad frames -> err_cnt_o saturates at 255.
